vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ACTIVE_W, default 512, active-display width in screen columns.
REQ-002 SHALL have parameter ACTIVE_H, default 480, active-display height in screen lines.
REQ-003 SHALL have parameter WBUF_DEPTH, default 4, host write-buffer depth (power of two).
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have port line  in  10  current VGA line.
REQ-007 SHALL have port column  in  10  current VGA column.
REQ-008 SHALL have port ppu_addr  in  16  tile-fetch address from the pixel core.
REQ-009 SHALL have port ppu_data  out  8  fetch data to the pixel core.
REQ-010 SHALL have port mem_addr  out  16  VRAM address.
REQ-011 SHALL have port mem_wdata  out  8  VRAM write data.
REQ-012 SHALL have port mem_we  out  1  VRAM write strobe.
REQ-013 SHALL have port mem_rdata  in  8  VRAM read data, valid one cycle after its address.
REQ-014 SHALL have port host_req, host_we  in  1 each  host request and direction (1 = write).
REQ-015 SHALL have port host_addr  in  16  host address.
REQ-016 SHALL have port host_wdata  in  8  host write data.
REQ-017 SHALL have port host_ack  out  1  one-cycle request-complete pulse.
REQ-018 SHALL have port host_rdata  out  8  host read data, valid while host_ack is high.
REQ-019 SHALL have port wbuf_count  out  log2(WBUF_DEPTH)+1  write-buffer occupancy.

Function
REQ-020 SHALL define ppu_window = (column < ACTIVE_W) AND (line < ACTIVE_H), evaluated combinationally each cycle.
REQ-021 SHALL, while ppu_window=1, drive mem_addr=ppu_addr and mem_we=0, and grant the host no VRAM cycle.
REQ-022 SHALL drive ppu_data=mem_rdata at all times (pass-through, no added latency).
REQ-023 SHALL accept a host request only while host_req=1 and host_ack=0, so a held request is taken once.
REQ-024 SHALL push a write (host_we=1) into the FIFO write buffer when wbuf_count<WBUF_DEPTH and assert host_ack the next cycle, regardless of ppu_window.
REQ-025 SHALL stall a write while the buffer is full; fullness is judged on registered count, so a pop in the same cycle does not admit the push.
REQ-026 SHALL use states IDLE and RD_DATA.
REQ-027 SHALL, in IDLE with ppu_window=0 and buffer non-empty, pop the head entry and drive it as mem_addr/mem_wdata with mem_we=1, one entry per cycle.
REQ-028 SHALL hold a host read until the buffer is empty, preserving write-before-read order.
REQ-029 SHALL, in IDLE with ppu_window=0, buffer empty and an accepted read pending, drive mem_addr=host_addr, mem_we=0, and go to RD_DATA.
REQ-030 SHALL, in RD_DATA, register mem_rdata into host_rdata, assert host_ack the following cycle, and return to IDLE; read latency is 2 cycles after issue.
REQ-031 SHALL, with ppu_window=0 and no host activity, drive mem_addr=ppu_addr and mem_we=0.
REQ-032 SHALL allow RD_DATA to complete even if ppu_window rises during it, since RD_DATA issues no VRAM address.
REQ-033 SHALL allow a push and a pop in the same cycle, leaving wbuf_count unchanged.
REQ-034 SHALL wrap the buffer read and write pointers modulo WBUF_DEPTH.

Reset
REQ-035 SHALL, when reset=0, asynchronously force IDLE, wbuf_count=0, both pointers=0, host_ack=0 and host_rdata=0.
REQ-036 SHALL discard all buffered writes and any in-flight read on reset, with no host_ack issued.
REQ-037 SHALL drive mem_we=0 throughout reset.

Verification
REQ-038 SHALL cover: line=500, host write 0x1234<-0xAB -> host_ack next cycle; mem_we=1, addr 0x1234, data 0xAB the cycle after.
REQ-039 SHALL cover: line=10, column=100, five writes -> four acks; fifth stalls; count=4; no mem_we until column>=512, then four drains in order.
REQ-040 SHALL cover: two buffered writes, then a read of 0x0020 in blanking -> read issued after both drains; host_rdata equals the second write's data if it targeted 0x0020.
REQ-041 SHALL cover: read issued at column 511 -> RD_DATA at column 512; host_ack one cycle later with correct data; mem_addr=ppu_addr from column 512.
REQ-042 SHALL cover: reset pulled low with count=3 and a read in RD_DATA -> count=0, no ack, mem_we=0; normal operation after release.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Host-side request/acknowledge bus of the VRAM arbiter.
// The host drives a request with direction, address and write data; the
// arbiter answers with a one-cycle acknowledge and, for reads, the data.
interface vram_arbiter_if;
   logic        host_req;
   logic        host_we;
   logic [15:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_ack;
   logic [7:0]  host_rdata;

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_ack, host_rdata
   );

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_ack, host_rdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: the pixel core owns VRAM inside the active display window;
// host writes are posted into a small FIFO and drained during blanking,
// host reads wait for the FIFO to empty so they always observe prior writes.
module vram_arbiter #(
   parameter int ACTIVE_W   = 512,
   parameter int ACTIVE_H   = 480,
   parameter int WBUF_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [9:0]                    line,
   input  logic [9:0]                    column,
   input  logic [15:0]                   ppu_addr,
   output logic [7:0]                    ppu_data,
   output logic [15:0]                   mem_addr,
   output logic [7:0]                    mem_wdata,
   output logic                          mem_we,
   input  logic [7:0]                    mem_rdata,
   vram_arbiter_if.slave                 host,
   output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [10:0]   ACT_W   = 11'(ACTIVE_W);
   localparam logic [10:0]   ACT_H   = 11'(ACTIVE_H);
   localparam logic [CW-1:0] DEPTH_C = CW'(WBUF_DEPTH);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_DATA = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [15:0]     buf_addr [WBUF_DEPTH];
   logic [7:0]      buf_data [WBUF_DEPTH];
   logic            rd_pending;
   logic [15:0]     rd_addr;

   logic            ppu_window;
   logic            push;
   logic            accept_rd;
   logic            read_want;
   logic [15:0]     read_addr;
   logic            pop;
   logic            issue;

   assign ppu_data   = mem_rdata;
   assign wbuf_count = count;

   // Arbitration decisions: window, request acceptance, drain and read issue.
   // A read is taken only once (latched in rd_pending) and may issue in the
   // same cycle it is accepted; fullness uses the registered count only.
   always_comb begin
      ppu_window = ({1'b0, column} < ACT_W) && ({1'b0, line} < ACT_H);
      accept_rd  = host.host_req && !host.host_we && !host.host_ack &&
                   !rd_pending && (state == IDLE);
      push       = host.host_req && host.host_we && !host.host_ack &&
                   !rd_pending && (state == IDLE) && (count < DEPTH_C);
      read_want  = rd_pending || accept_rd;
      if (rd_pending) begin
         read_addr = rd_addr;
      end else begin
         read_addr = host.host_addr;
      end
      pop   = reset && (state == IDLE) && !ppu_window && (count != '0);
      issue = reset && (state == IDLE) && !ppu_window && (count == '0) && read_want;
   end

   // Next state and VRAM bus: pixel fetch by default, FIFO drain, read issue.
   always_comb begin
      state_nxt = state;
      mem_addr  = ppu_addr;
      mem_wdata = 8'h00;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (pop) begin
               mem_addr  = buf_addr[rd_ptr];
               mem_wdata = buf_data[rd_ptr];
               mem_we    = 1'b1;
            end else if (issue) begin
               mem_addr  = read_addr;
               state_nxt = RD_DATA;
            end else begin
               state_nxt = IDLE;
            end
         end
         RD_DATA: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Write buffer: storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < WBUF_DEPTH; i++) begin
            buf_addr[i] <= 16'h0000;
            buf_data[i] <= 8'h00;
         end
      end else begin
         if (push) begin
            buf_addr[wr_ptr] <= host.host_addr;
            buf_data[wr_ptr] <= host.host_wdata;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Host read tracking and registered host responses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pending      <= 1'b0;
         rd_addr         <= 16'h0000;
         host.host_ack   <= 1'b0;
         host.host_rdata <= 8'h00;
      end else begin
         if (accept_rd) begin
            rd_pending <= 1'b1;
            rd_addr    <= host.host_addr;
         end else if (state == RD_DATA) begin
            rd_pending <= 1'b0;
         end
         host.host_ack <= push || (state == RD_DATA);
         if (state == RD_DATA) begin
            host.host_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural VRAM (one-cycle read
// latency). Unwritten VRAM locations read back as addr[7:0] ^ addr[15:8].
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  line;
   logic [9:0]  column;
   logic [15:0] ppu_addr;
   logic [7:0]  ppu_data;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata = 8'h00;
   logic [2:0]  wbuf_count;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  vram    [0:65535];
   bit          written [0:65535];
   logic [23:0] wlog [$];

   vram_arbiter_if host_bus();

   vram_arbiter #(.ACTIVE_W(512), .ACTIVE_H(480), .WBUF_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .line       (line),
      .column     (column),
      .ppu_addr   (ppu_addr),
      .ppu_data   (ppu_data),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .host       (host_bus),
      .wbuf_count (wbuf_count)
   );

   always #5 clk = ~clk;

   // Behavioural VRAM with write log.
   always @(posedge clk) begin
      if (mem_we) begin
         vram[mem_addr]    <= mem_wdata;
         written[mem_addr] <= 1'b1;
         wlog.push_back({mem_addr, mem_wdata});
      end
      if (written[mem_addr]) mem_rdata <= vram[mem_addr];
      else                   mem_rdata <= mem_addr[7:0] ^ mem_addr[15:8];
   end

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, output bit got);
      got = 1'b0;
      @(negedge clk);
      host_bus.host_req = 1'b1; host_bus.host_we = 1'b1;
      host_bus.host_addr = a;   host_bus.host_wdata = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (host_bus.host_ack) begin got = 1'b1; break; end
      end
      host_bus.host_req = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] a, output bit got, output logic [7:0] d);
      got = 1'b0; d = 8'h00;
      @(negedge clk);
      host_bus.host_req = 1'b1; host_bus.host_we = 1'b0; host_bus.host_addr = a;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (host_bus.host_ack) begin got = 1'b1; d = host_bus.host_rdata; break; end
      end
      host_bus.host_req = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      vectors++; if (wbuf_count !== 3'd0) begin miscompares++; $display("FAIL rst_count got=%0d exp=0", wbuf_count); end
      vectors++; if (host_bus.host_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack got=%b exp=0", host_bus.host_ack); end
      vectors++; if (host_bus.host_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata got=%h exp=00", host_bus.host_rdata); end
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got=%b exp=0", mem_we); end
      vectors++; if (mem_addr !== 16'h4321) begin miscompares++; $display("FAIL rst_addr got=%h exp=4321", mem_addr); end
      line = 10'd500; #1;
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we_blank got=%b exp=0", mem_we); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_window_passthrough();
      @(negedge clk);
      line = 10'd10; column = 10'd100; ppu_addr = 16'h4321; #1;
      vectors++; if (mem_addr !== 16'h4321 || mem_we !== 1'b0) begin miscompares++; $display("FAIL win_addr got=%h/%b exp=4321/0", mem_addr, mem_we); end
      @(negedge clk); #1;
      vectors++; if (ppu_data !== 8'h62) begin miscompares++; $display("FAIL win_data got=%h exp=62", ppu_data); end
      ppu_addr = 16'hA5F0; #1;
      vectors++; if (mem_addr !== 16'hA5F0) begin miscompares++; $display("FAIL win_addr2 got=%h exp=a5f0", mem_addr); end
      @(negedge clk); #1;
      vectors++; if (ppu_data !== 8'h55) begin miscompares++; $display("FAIL win_data2 got=%h exp=55", ppu_data); end
      line = 10'd500; ppu_addr = 16'h0BEE; #1;
      vectors++; if (mem_addr !== 16'h0BEE || mem_we !== 1'b0) begin miscompares++; $display("FAIL blank_idle got=%h/%b exp=0bee/0", mem_addr, mem_we); end
   endtask

   task automatic test_single_write();
      @(negedge clk);
      line = 10'd500; column = 10'd0;
      host_bus.host_req = 1'b1; host_bus.host_we = 1'b1;
      host_bus.host_addr = 16'h1234; host_bus.host_wdata = 8'hAB; #1;
      vectors++; if (host_bus.host_ack !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL sw_req got=%b/%b exp=0/0", host_bus.host_ack, mem_we); end
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b1) begin miscompares++; $display("FAIL sw_ack got=%b exp=1", host_bus.host_ack); end
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 16'h1234 || mem_wdata !== 8'hAB) begin miscompares++; $display("FAIL sw_mem got=%b/%h/%h exp=1/1234/ab", mem_we, mem_addr, mem_wdata); end
      host_bus.host_req = 1'b0;
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b0 || mem_we !== 1'b0 || wbuf_count !== 3'd0) begin miscompares++; $display("FAIL sw_after got=%b/%b/%0d exp=0/0/0", host_bus.host_ack, mem_we, wbuf_count); end
   endtask

   task automatic test_full_stall();
      bit got;
      @(negedge clk);
      line = 10'd10; column = 10'd100;
      wlog.delete();
      for (int i = 0; i < 4; i++) begin
         do_write(16'h0100 + 16'(i), 8'h10 + 8'(i), got);
         vectors++; if (!got) begin miscompares++; $display("FAIL full_ack%0d got=no-ack exp=ack", i); end
      end
      @(negedge clk);
      host_bus.host_req = 1'b1; host_bus.host_we = 1'b1;
      host_bus.host_addr = 16'h0104; host_bus.host_wdata = 8'h14;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         vectors++; if (host_bus.host_ack !== 1'b0 || mem_we !== 1'b0 || wbuf_count !== 3'd4) begin miscompares++; $display("FAIL full_stall got=%b/%b/%0d exp=0/0/4", host_bus.host_ack, mem_we, wbuf_count); end
      end
      vectors++; if (wlog.size() != 0) begin miscompares++; $display("FAIL full_nodrain got=%0d exp=0", wlog.size()); end
      column = 10'd512; #1;
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 8'h10) begin miscompares++; $display("FAIL full_drain0 got=%b/%h/%h exp=1/0100/10", mem_we, mem_addr, mem_wdata); end
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (host_bus.host_ack) begin got = 1'b1; break; end
      end
      host_bus.host_req = 1'b0;
      vectors++; if (!got) begin miscompares++; $display("FAIL full_ack5 got=no-ack exp=ack"); end
      for (int i = 0; i < 10; i++) begin
         if (wbuf_count == 3'd0) break;
         @(negedge clk); #1;
      end
      vectors++; if (wbuf_count !== 3'd0) begin miscompares++; $display("FAIL full_empty got=%0d exp=0", wbuf_count); end
      vectors++; if (wlog.size() != 5) begin miscompares++; $display("FAIL full_logsize got=%0d exp=5", wlog.size()); end
      for (int i = 0; i < 5 && i < wlog.size(); i++) begin
         vectors++; if (wlog[i] !== {16'h0100 + 16'(i), 8'h10 + 8'(i)}) begin miscompares++; $display("FAIL full_order%0d got=%h exp=%h", i, wlog[i], {16'h0100 + 16'(i), 8'h10 + 8'(i)}); end
      end
   endtask

   task automatic test_write_read_order();
      bit got;
      @(negedge clk);
      line = 10'd10; column = 10'd100; ppu_addr = 16'h0BEE;
      do_write(16'h0010, 8'h55, got);
      do_write(16'h0020, 8'h66, got);
      vectors++; if (wbuf_count !== 3'd2) begin miscompares++; $display("FAIL wr_count got=%0d exp=2", wbuf_count); end
      @(negedge clk);
      host_bus.host_req = 1'b1; host_bus.host_we = 1'b0; host_bus.host_addr = 16'h0020;
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL wr_hold got=%b/%b exp=0/0", host_bus.host_ack, mem_we); end
      line = 10'd500; #1;
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 8'h55) begin miscompares++; $display("FAIL wr_drain0 got=%b/%h/%h exp=1/0010/55", mem_we, mem_addr, mem_wdata); end
      @(negedge clk); #1;
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 8'h66) begin miscompares++; $display("FAIL wr_drain1 got=%b/%h/%h exp=1/0020/66", mem_we, mem_addr, mem_wdata); end
      @(negedge clk); #1;
      vectors++; if (mem_we !== 1'b0 || mem_addr !== 16'h0020) begin miscompares++; $display("FAIL wr_issue got=%b/%h exp=0/0020", mem_we, mem_addr); end
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b0 || mem_addr !== 16'h0BEE) begin miscompares++; $display("FAIL wr_rddata got=%b/%h exp=0/0bee", host_bus.host_ack, mem_addr); end
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b1 || host_bus.host_rdata !== 8'h66) begin miscompares++; $display("FAIL wr_rdack got=%b/%h exp=1/66", host_bus.host_ack, host_bus.host_rdata); end
      host_bus.host_req = 1'b0;
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ackpulse got=%b exp=0", host_bus.host_ack); end
   endtask

   task automatic test_read_boundary();
      @(negedge clk);
      line = 10'd479; column = 10'd511; ppu_addr = 16'h0BEE;
      host_bus.host_req = 1'b1; host_bus.host_we = 1'b1;
      host_bus.host_addr = 16'h0200; host_bus.host_wdata = 8'h77;
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b1 || mem_we !== 1'b0 || wbuf_count !== 3'd1) begin miscompares++; $display("FAIL edge_win got=%b/%b/%0d exp=1/0/1", host_bus.host_ack, mem_we, wbuf_count); end
      host_bus.host_req = 1'b0; column = 10'd512; #1;
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 16'h0200) begin miscompares++; $display("FAIL edge_drain got=%b/%h exp=1/0200", mem_we, mem_addr); end
      @(negedge clk);
      line = 10'd480; column = 10'd511;
      host_bus.host_req = 1'b1; host_bus.host_we = 1'b0; host_bus.host_addr = 16'h7F21; #1;
      vectors++; if (mem_we !== 1'b0 || mem_addr !== 16'h7F21) begin miscompares++; $display("FAIL c511_issue got=%b/%h exp=0/7f21", mem_we, mem_addr); end
      @(negedge clk); column = 10'd512; #1;
      vectors++; if (host_bus.host_ack !== 1'b0 || mem_addr !== 16'h0BEE) begin miscompares++; $display("FAIL c512_rd got=%b/%h exp=0/0bee", host_bus.host_ack, mem_addr); end
      @(negedge clk); column = 10'd513; #1;
      vectors++; if (host_bus.host_ack !== 1'b1 || host_bus.host_rdata !== 8'h5E || mem_addr !== 16'h0BEE) begin miscompares++; $display("FAIL c513_ack got=%b/%h/%h exp=1/5e/0bee", host_bus.host_ack, host_bus.host_rdata, mem_addr); end
      host_bus.host_req = 1'b0;
      @(negedge clk);
      line = 10'd500; column = 10'd0;
      host_bus.host_req = 1'b1; host_bus.host_we = 1'b0; host_bus.host_addr = 16'h1E0F; #1;
      vectors++; if (mem_addr !== 16'h1E0F) begin miscompares++; $display("FAIL winrise_issue got=%h exp=1e0f", mem_addr); end
      @(negedge clk); line = 10'd10; column = 10'd100; #1;
      vectors++; if (mem_addr !== 16'h0BEE || mem_we !== 1'b0) begin miscompares++; $display("FAIL winrise_rd got=%h/%b exp=0bee/0", mem_addr, mem_we); end
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b1 || host_bus.host_rdata !== 8'h11) begin miscompares++; $display("FAIL winrise_ack got=%b/%h exp=1/11", host_bus.host_ack, host_bus.host_rdata); end
      host_bus.host_req = 1'b0;
   endtask

   task automatic test_reset_midflight();
      bit got;
      logic [7:0] d;
      @(negedge clk);
      line = 10'd10; column = 10'd100;
      for (int i = 0; i < 3; i++) do_write(16'h0300 + 16'(i), 8'hC0 + 8'(i), got);
      vectors++; if (wbuf_count !== 3'd3) begin miscompares++; $display("FAIL mid_count got=%0d exp=3", wbuf_count); end
      @(negedge clk); reset = 1'b0; #1;
      vectors++; if (wbuf_count !== 3'd0 || host_bus.host_ack !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst got=%0d/%b/%b exp=0/0/0", wbuf_count, host_bus.host_ack, mem_we); end
      line = 10'd500; #1;
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst_blank got=%b exp=0", mem_we); end
      @(negedge clk); reset = 1'b1; wlog.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_discard got=%b exp=0", mem_we); end
      end
      vectors++; if (wlog.size() != 0) begin miscompares++; $display("FAIL mid_log got=%0d exp=0", wlog.size()); end
      @(negedge clk);
      host_bus.host_req = 1'b1; host_bus.host_we = 1'b0; host_bus.host_addr = 16'h7F21; #1;
      vectors++; if (mem_addr !== 16'h7F21) begin miscompares++; $display("FAIL mid_issue got=%h exp=7f21", mem_addr); end
      @(negedge clk); reset = 1'b0; host_bus.host_req = 1'b0; #1;
      vectors++; if (host_bus.host_ack !== 1'b0 || host_bus.host_rdata !== 8'h00) begin miscompares++; $display("FAIL mid_rdrst got=%b/%h exp=0/00", host_bus.host_ack, host_bus.host_rdata); end
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_noack got=%b/%b exp=0/0", host_bus.host_ack, mem_we); end
      reset = 1'b1;
      @(negedge clk); #1;
      vectors++; if (host_bus.host_ack !== 1'b0) begin miscompares++; $display("FAIL mid_release got=%b exp=0", host_bus.host_ack); end
      do_write(16'h0042, 8'h99, got);
      vectors++; if (!got) begin miscompares++; $display("FAIL post_wr got=no-ack exp=ack"); end
      do_read(16'h0042, got, d);
      vectors++; if (!got || d !== 8'h99) begin miscompares++; $display("FAIL post_rd got=%b/%h exp=1/99", got, d); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset = 1'b0;
      line = 10'd10; column = 10'd100; ppu_addr = 16'h4321;
      host_bus.host_req = 1'b0; host_bus.host_we = 1'b0;
      host_bus.host_addr = 16'h0000; host_bus.host_wdata = 8'h00;
      test_reset();
      test_window_passthrough();
      test_single_write();
      test_full_stall();
      test_write_read_order();
      test_read_boundary();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
